// File: rtl/switch_alu_cpu.sv
// Switch-driven register CPU: one ALU op per debounced botao1 press, result printed
// as hex on a character LCD. Define SAT_ARITH_EN for saturating ADD/SUB.
module switch_alu_cpu #(
    parameter int DW      = 4,
    parameter int NREG    = 4,
    parameter int DB_CYC  = 16,
    parameter int EN_CYC  = 20,
    parameter int CLR_CYC = 100,
    localparam int RW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    op,
    input  logic [RW-1:0] d_sel,
    input  logic [DW-1:0] imm,
    input  logic          botao1,
    input  logic          botao2,
    output logic          lcd_en,
    output logic          lcd_rs,
    output logic          lcd_wr,
    output logic [7:0]    dado,
    output logic [5:0]    ledV,
    output logic          busy
);
    localparam int ND   = (DW + 3) / 4;
    localparam int PW   = ND * 4;
    localparam int NW   = (ND > 1) ? $clog2(ND) : 1;
    localparam int CMAX = (EN_CYC > CLR_CYC) ? EN_CYC : CLR_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int DBW  = $clog2(DB_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WB, S_PUT, S_CLR, S_WAIT} state_t;
    typedef enum logic [1:0] {PH_SET, PH_HI, PH_LO} phase_t;

    function automatic logic [7:0] hex_char(input logic [PW-1:0] v, input int idx);
        logic [3:0] n;
        n = v[idx*4 +: 4];
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    state_t            state_q, state_d;
    phase_t            ph_q, ph_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NW-1:0]     nib_q, nib_d;
    logic [DW-1:0]     res_q, res_d;
    logic              resc_q, resc_d, ress_q, ress_d;
    logic [RW-1:0]     dsel_q, dsel_d;
    logic              carry_q, carry_d, zero_q, zero_d, sat_q, sat_d;
    logic [1:0]        lsel_q, lsel_d;
    logic              en_q, en_d, rs_q, rs_d;
    logic [7:0]        dado_q, dado_d;
    logic [DW-1:0]     regs_q [NREG];
    logic [DW-1:0]     regs_d [NREG];

    logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, press;
    logic [1:0][DBW-1:0]  dbc_q, dbc_d;

    // Keys idle high; a press is the debounced level falling.
    always_comb begin
        sync1_d = {botao2, botao1};
        sync2_d = sync1_q;
        db_d    = db_q;
        dbc_d   = dbc_q;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == db_q[k]) begin
                dbc_d[k] = '0;
            end else if (dbc_q[k] == DBW'(DB_CYC - 1)) begin
                db_d[k]  = sync2_q[k];
                dbc_d[k] = '0;
            end else begin
                dbc_d[k] = dbc_q[k] + 1'b1;
            end
        end
        press = db_q & ~db_d;
    end

    logic [DW-1:0] r, alu_res;
    logic [DW:0]   wide;
    logic          alu_c, alu_s;

    always_comb begin
        r       = regs_q[d_sel];
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_s   = 1'b0;
        case (op)
            3'b000: alu_res = imm;
            3'b001: begin
                wide    = {1'b0, r} + {1'b0, imm};
                alu_res = wide[DW-1:0];
                alu_c   = wide[DW];
`ifdef SAT_ARITH_EN
                if (alu_c) begin
                    alu_res = '1;
                    alu_s   = 1'b1;
                end
`endif
            end
            3'b010: begin
                // Top bit of the widened difference is the borrow.
                wide    = {1'b0, r} - {1'b0, imm};
                alu_res = wide[DW-1:0];
                alu_c   = wide[DW];
`ifdef SAT_ARITH_EN
                if (alu_c) begin
                    alu_res = '0;
                    alu_s   = 1'b1;
                end
`endif
            end
            3'b011: alu_res = r & imm;
            3'b100: alu_res = r | imm;
            3'b101: alu_res = r ^ imm;
            3'b110: begin
                alu_res = {r[DW-2:0], 1'b0};
                alu_c   = r[DW-1];
            end
            default: alu_res = '0;
        endcase
    end

    logic [PW-1:0] res_pad;
    assign res_pad = PW'(res_q);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        res_d   = res_q;
        resc_d  = resc_q;
        ress_d  = ress_q;
        dsel_d  = dsel_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        sat_d   = sat_q;
        lsel_d  = lsel_q;
        en_d    = en_q;
        rs_d    = rs_q;
        dado_d  = dado_q;
        regs_d  = regs_q;
        case (state_q)
            S_IDLE: begin
                if (press[0]) begin
                    state_d = S_EXEC;
                end else if (press[1]) begin
                    state_d = S_CLR;
                    rs_d    = 1'b0;
                    dado_d  = 8'h01;
                    ph_d    = PH_SET;
                    cnt_d   = '0;
                end
            end
            S_EXEC: begin
                res_d   = alu_res;
                resc_d  = alu_c;
                ress_d  = alu_s;
                dsel_d  = d_sel;
                state_d = S_WB;
            end
            S_WB: begin
                regs_d[dsel_q] = res_q;
                carry_d = resc_q;
                zero_d  = (res_q == '0);
                sat_d   = ress_q;
                lsel_d  = 2'(dsel_q);
                nib_d   = NW'(ND - 1);
                rs_d    = 1'b1;
                dado_d  = hex_char(res_pad, ND - 1);
                ph_d    = PH_SET;
                cnt_d   = '0;
                state_d = S_PUT;
            end
            S_PUT: begin
                case (ph_q)
                    PH_SET: begin
                        en_d = 1'b1;
                        ph_d = PH_HI;
                    end
                    PH_HI: begin
                        if (cnt_q == CW'(EN_CYC - 1)) begin
                            en_d  = 1'b0;
                            ph_d  = PH_LO;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        if (cnt_q == CW'(EN_CYC - 1)) begin
                            cnt_d = '0;
                            if (nib_q == '0) begin
                                state_d = S_IDLE;
                            end else begin
                                nib_d  = nib_q - 1'b1;
                                dado_d = hex_char(res_pad, int'(nib_q) - 1);
                                ph_d   = PH_SET;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                endcase
            end
            S_CLR: begin
                if (ph_q == PH_SET) begin
                    en_d = 1'b1;
                    ph_d = PH_HI;
                end else if (cnt_q == CW'(EN_CYC - 1)) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(CLR_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= PH_SET;
            cnt_q   <= '0;
            nib_q   <= '0;
            res_q   <= '0;
            resc_q  <= 1'b0;
            ress_q  <= 1'b0;
            dsel_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            sat_q   <= 1'b0;
            lsel_q  <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            dado_q  <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            db_q    <= 2'b11;
            dbc_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            res_q   <= res_d;
            resc_q  <= resc_d;
            ress_q  <= ress_d;
            dsel_q  <= dsel_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            sat_q   <= sat_d;
            lsel_q  <= lsel_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            dado_q  <= dado_d;
            regs_q  <= regs_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            dbc_q   <= dbc_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign lcd_en = en_q;
    assign lcd_rs = rs_q;
    assign lcd_wr = 1'b0;
    assign dado   = dado_q;
    assign ledV   = {busy, carry_q, zero_q, sat_q, lsel_q};
endmodule

// File: tb/tb_switch_alu_cpu.sv
// Bench for switch_alu_cpu: a DW=4 and a DW=8 instance share keys and op switches,
// checked against an arithmetic model plus an LCD character queue per instance.
module tb_switch_alu_cpu;
    localparam int EN  = 2;
    localparam int CLR = 10;
    localparam int DB  = 4;

    logic       clk = 1'b0;
    logic       rst, b1, b2;
    logic [2:0] op;
    logic [1:0] d_sel;
    logic [3:0] imm4;
    logic [7:0] imm8;
    logic       en0, rs0, wr0, busy0, en1, rs1, wr1, busy1;
    logic [7:0] dado0, dado1;
    logic [5:0] led0, led1;

    always #5 clk = ~clk;

    switch_alu_cpu #(.DW(4), .NREG(4), .DB_CYC(DB), .EN_CYC(EN), .CLR_CYC(CLR)) dut4 (
        .clk(clk), .rst(rst), .op(op), .d_sel(d_sel), .imm(imm4), .botao1(b1), .botao2(b2),
        .lcd_en(en0), .lcd_rs(rs0), .lcd_wr(wr0), .dado(dado0), .ledV(led0), .busy(busy0));

    switch_alu_cpu #(.DW(8), .NREG(4), .DB_CYC(DB), .EN_CYC(EN), .CLR_CYC(CLR)) dut8 (
        .clk(clk), .rst(rst), .op(op), .d_sel(d_sel), .imm(imm8), .botao1(b1), .botao2(b2),
        .lcd_en(en1), .lcd_rs(rs1), .lcd_wr(wr1), .dado(dado1), .ledV(led1), .busy(busy1));

    int checks = 0;
    int errors = 0;

    int mreg[2][4];
    int mc[2], mz[2], ms[2], ml[2];
    int q0[$];
    int q1[$];
    int prev_en[2], hi_cnt[2], lastc[2], prevc[2], nstrobe[2];

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) mreg[i][j] = 0;
            mc[i] = 0; mz[i] = 0; ms[i] = 0; ml[i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Expected characters are {rs, dado}; 9'h001 is the clear command.
    task automatic model_exec(input int i, input int o, input int d, input int im);
        int w, m, r, res, c, s, nib, ch;
        w = (i == 0) ? 4 : 8;
        m = 1 << w;
        r = mreg[i][d];
        c = 0; s = 0; res = 0;
        case (o)
            0: res = im;
            1: begin
                res = r + im; c = (res >= m) ? 1 : 0; res = res % m;
`ifdef SAT_ARITH_EN
                if (c == 1) begin res = m - 1; s = 1; end
`endif
            end
            2: begin
                c = (im > r) ? 1 : 0; res = (r - im + m) % m;
`ifdef SAT_ARITH_EN
                if (c == 1) begin res = 0; s = 1; end
`endif
            end
            3: res = r & im;
            4: res = r | im;
            5: res = r ^ im;
            6: begin res = r * 2; c = (res >= m) ? 1 : 0; res = res % m; end
            default: res = 0;
        endcase
        mreg[i][d] = res;
        mc[i] = c; mz[i] = (res == 0) ? 1 : 0; ms[i] = s; ml[i] = d;
        for (int k = w / 4 - 1; k >= 0; k--) begin
            nib = (res >> (4 * k)) & 15;
            ch = 256 + ((nib < 10) ? 48 + nib : 55 + nib);
            if (i == 0) q0.push_back(ch); else q1.push_back(ch);
        end
    endtask

    task automatic mon(input int i, input logic en, input logic rs, input logic [7:0] dd,
                       input logic [5:0] led, input logic bz, input logic wr);
        int exp;
        if (rst) begin
            prev_en[i] = 0; hi_cnt[i] = 0;
            return;
        end
        if (en && prev_en[i] == 0) begin
            nstrobe[i]++;
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                checks++; errors++;
                $display("FAIL strobe%0d: unexpected strobe got %0h expected none", i, {rs, dd});
            end else begin
                exp = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("lcd char%0d", i), {23'd0, rs, dd}, exp);
            end
            prevc[i] = lastc[i];
            lastc[i] = {23'd0, rs, dd};
            hi_cnt[i] = 1;
        end else if (en) begin
            hi_cnt[i]++;
        end
        if (!en && prev_en[i] == 1) chk($sformatf("en width%0d", i), hi_cnt[i], EN);
        if (!bz) begin
            chk($sformatf("idle ledV%0d", i), int'(led[4:0]), mc[i]*16 + mz[i]*8 + ms[i]*4 + ml[i]);
            chk($sformatf("idle en%0d", i), int'(en), 0);
            chk($sformatf("wr%0d", i), int'(wr), 0);
        end
        prev_en[i] = en ? 1 : 0;
    endtask

    always @(negedge clk) begin
        mon(0, en0, rs0, dado0, led0, busy0, wr0);
        mon(1, en1, rs1, dado1, led1, busy1, wr1);
    end

    // kind: 1 execute, 2 clear, 3 both keys together.
    task automatic do_op(input int kind, input int o, input int d, input int i4, input int i8,
                         input bit bounce, input bit drop);
        int n, dur, seen;
        op = 3'(o); d_sel = 2'(d); imm4 = 4'(i4); imm8 = 8'(i8);
        @(negedge clk);
        if (bounce) begin
            b1 = 0; @(negedge clk); b1 = 1; @(negedge clk);
            b1 = 0; @(negedge clk); b1 = 1; @(negedge clk);
        end
        b1 = (kind & 1) ? 1'b0 : 1'b1;
        b2 = (kind & 2) ? 1'b0 : 1'b1;
        n = 0;
        while (!busy0 && n < 40) begin @(negedge clk); n++; end
        chk("accept", int'(busy0), 1);
        chk("accept dut8", int'(busy1), 1);
        if (kind == 2) begin
            q0.push_back(1); q1.push_back(1);
        end else begin
            model_exec(0, o, d, i4);
            model_exec(1, o, d, i8);
        end
        if (drop) begin
            op = 3'b000; d_sel = 2'd1; imm4 = 4'hF; imm8 = 8'hFF; b1 = 0;
        end
        dur = 0;
        while (busy0 && dur < 200) begin @(negedge clk); dur++; end
        chk("busy length", dur, (kind == 2) ? 1 + EN + CLR : 2 + 1 + 2 * EN);
        n = 0;
        while (busy1 && n < 200) begin @(negedge clk); n++; end
        chk("dut8 done", int'(busy1), 0);
        repeat (12) @(negedge clk);
        b1 = 1; b2 = 1;
        seen = 0;
        repeat (20) begin @(negedge clk); if (busy0 || busy1) seen = 1; end
        chk("no extra exec", seen, 0);
    endtask

    initial begin
        int n, s0;
        rst = 1; b1 = 1; b2 = 1; op = 0; d_sel = 0; imm4 = 0; imm8 = 0;
        for (int i = 0; i < 2; i++) begin
            prev_en[i] = 0; hi_cnt[i] = 0; lastc[i] = 0; prevc[i] = 0; nstrobe[i] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst en", int'(en0), 0);
        chk("rst rs", int'(rs0), 0);
        chk("rst dado", int'(dado0), 0);
        chk("rst ledV", int'(led0), 0);
        chk("rst busy", int'(busy0), 0);
        chk("rst ledV8", int'(led1), 0);
        rst = 0;
        repeat (10) @(negedge clk);

        s0 = nstrobe[0];
        do_op(1, 0, 1, 9, 9, 0, 0);
        chk("t1 ledV", int'(led0), 6'b000001);
        chk("t1 char", lastc[0], 9'h139);
        chk("t1 one strobe", nstrobe[0] - s0, 1);

        do_op(1, 1, 1, 8, 8, 0, 0);
`ifdef SAT_ARITH_EN
        chk("t2 ledV", int'(led0), 6'b010101);
        chk("t2 char", lastc[0], 9'h146);
`else
        chk("t2 ledV", int'(led0), 6'b010001);
        chk("t2 char", lastc[0], 9'h131);
`endif

        do_op(1, 0, 2, 3, 3, 0, 0);
        do_op(1, 2, 2, 3, 3, 0, 0);
        chk("t3 zero ledV", int'(led0), 6'b001010);
        do_op(1, 2, 2, 1, 1, 0, 0);
`ifdef SAT_ARITH_EN
        chk("t3 borrow ledV", int'(led0), 6'b011110);
`else
        chk("t3 borrow ledV", int'(led0), 6'b010010);
        chk("t3 borrow char", lastc[0], 9'h146);
`endif

        do_op(1, 3, 1, 4'hF, 8'hFF, 1, 0);
        s0 = nstrobe[0];
        do_op(2, 0, 0, 0, 0, 0, 1);
        chk("t5 clear char", lastc[0], 9'h001);
        chk("t5 clear strobes", nstrobe[0] - s0, 1);
        do_op(1, 4, 1, 0, 0, 0, 0);
        do_op(3, 5, 1, 5, 5, 0, 0);
        do_op(1, 6, 2, 0, 0, 0, 0);
        do_op(1, 0, 0, 4'hA, 8'h3A, 0, 0);
        do_op(1, 4, 0, 5, 5, 0, 0);
        do_op(1, 7, 0, 0, 0, 0, 0);

        op = 3'b000; d_sel = 2'd3; imm4 = 4'h7; imm8 = 8'h77;
        @(negedge clk);
        b1 = 0;
        n = 0;
        while (!busy0 && n < 40) begin @(negedge clk); n++; end
        chk("t6 accept", int'(busy0), 1);
        model_exec(0, 0, 3, 7);
        model_exec(1, 0, 3, 8'h77);
        n = 0;
        while (!en0 && n < 40) begin @(negedge clk); n++; end
        chk("t6 strobe up", int'(en0), 1);
        rst = 1; b1 = 1;
        model_reset();
        @(negedge clk);
        chk("t6 en", int'(en0), 0);
        chk("t6 busy", int'(busy0), 0);
        chk("t6 ledV", int'(led0), 0);
        chk("t6 en8", int'(en1), 0);
        chk("t6 busy8", int'(busy1), 0);
        rst = 0;
        repeat (12) @(negedge clk);
        do_op(1, 4, 3, 0, 0, 0, 0);
        chk("t6 reg cleared", int'(led0), 6'b001011);

        do_op(1, 0, 0, 5, 8'hA5, 0, 0);
        chk("dw8 hi char", prevc[1], 9'h141);
        chk("dw8 lo char", lastc[1], 9'h135);

        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
